// File: rtl/ripple_cla16_adder.sv
// Multi-cycle 16-bit adder: four 4-bit carry-lookahead nibble stages, one nibble per clock,
// carry rippling between nibbles through a register. Start/ready handshake on en/ready.
module ripple_cla16_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned NIBBLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   output logic [WIDTH-1:0] Output,
   output logic             c_out,
   output logic             ready
);

   localparam int unsigned NSTAGE = WIDTH / NIBBLE;
   localparam int unsigned KW     = $clog2(NSTAGE);
   localparam int unsigned LW     = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic              carry_q, carry_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WIDTH-1:0]  output_d;
   logic              c_out_d;
   logic              ready_d;

   logic [LW-1:0]     nib_lsb;
   logic [NIBBLE-1:0] a_nib;
   logic [NIBBLE-1:0] b_nib;
   logic [NIBBLE:0]   nib_res;

   // 4-bit carry-lookahead: all internal carries from g/p directly, returns {carry_out, sum}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   assign nib_lsb = LW'(k_q * NIBBLE);
   assign a_nib   = a_q[nib_lsb +: NIBBLE];
   assign b_nib   = b_q[nib_lsb +: NIBBLE];
   assign nib_res = cla4(a_nib, b_nib, carry_q);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         Output  <= '0;
         c_out   <= 1'b0;
         ready   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         Output  <= output_d;
         c_out   <= c_out_d;
         ready   <= ready_d;
      end
   end

   // Next-state and datapath update; result registers only move on the final nibble
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      k_d      = k_q;
      output_d = Output;
      c_out_d  = c_out;
      ready_d  = ready;
      case (state_q)
         IDLE: begin
            if (en) begin
               a_d     = A;
               b_d     = B;
               carry_d = c_in;
               k_d     = '0;
               acc_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (!en) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end else begin
               acc_d[nib_lsb +: NIBBLE] = nib_res[NIBBLE-1:0];
               carry_d                  = nib_res[NIBBLE];
               if (k_q == KW'(NSTAGE - 1)) begin
                  output_d = acc_d;
                  c_out_d  = nib_res[NIBBLE];
                  ready_d  = 1'b1;
                  k_d      = '0;
                  state_d  = DONE;
               end else begin
                  k_d = KW'(k_q + 1'b1);
               end
            end
         end
         DONE: begin
            if (!en) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ripple_cla16_adder.sv
// Directed bench for ripple_cla16_adder: hand-computed sums, latency, abort, operand
// stability and asynchronous reset.
module tb_ripple_cla16_adder;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] A;
   logic [15:0] B;
   logic        c_in;
   logic [15:0] out;
   logic        c_out;
   logic        ready;

   int checks;
   int errors;
   logic [16:0] last_res;

   ripple_cla16_adder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .A      (A),
      .B      (B),
      .c_in   (c_in),
      .Output (out),
      .c_out  (c_out),
      .ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives a new operation now (caller keeps this away from a clock edge), then follows it
   // through latency, hold and release. scramble changes the operands after capture.
   task automatic do_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [16:0] exp, input bit scramble);
      en   = 1'b1;
      A    = a;
      B    = b;
      c_in = cin;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk);
         #1;
         if (scramble) begin
            A    = 16'($urandom);
            B    = 16'($urandom);
            c_in = 1'($urandom);
         end
         if (e == 4) begin
            check({tag, "_rdy_e4"}, {16'h0, ready}, 17'h0);
            check({tag, "_hold_e4"}, {c_out, out}, last_res);
         end
      end
      check({tag, "_rdy_e5"}, {16'h0, ready}, 17'h1);
      check({tag, "_res"}, {c_out, out}, exp);
      @(posedge clk);
      #1;
      check({tag, "_rdy_hold"}, {16'h0, ready}, 17'h1);
      check({tag, "_res_hold"}, {c_out, out}, exp);
      en = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_rdy_drop"}, {16'h0, ready}, 17'h0);
      check({tag, "_res_drop"}, {c_out, out}, exp);
      last_res = exp;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_res = 17'h0;
      rst_n    = 1'b0;
      en       = 1'b0;
      A        = 16'h0;
      B        = 16'h0;
      c_in     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_res", {c_out, out}, 17'h0);
      check("reset_rdy", {16'h0, ready}, 17'h0);
      rst_n = 1'b1;

      do_add("basic", 16'd127, 16'd127, 1'b0, 17'h000FE, 1'b0);
      do_add("ripple", 16'h0FFF, 16'h0001, 1'b0, 17'h01000, 1'b0);
      do_add("wrap", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
      do_add("full_cin", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0);

      // Abort after two edges: no result, previous value kept
      en   = 1'b1;
      A    = 16'h00AA;
      B    = 16'h0055;
      c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      check("abort_rdy", {16'h0, ready}, 17'h0);
      check("abort_res", {c_out, out}, last_res);
      do_add("restart", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);

      do_add("stable", 16'h3C3C, 16'h4444, 1'b1, 17'h08081, 1'b1);

      // Asynchronous reset between edges in the middle of CALC
      en   = 1'b1;
      A    = 16'h7777;
      B    = 16'h0001;
      c_in = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_res", {c_out, out}, 17'h0);
      check("arst_rdy", {16'h0, ready}, 17'h0);
      last_res = 17'h0;
      @(negedge clk);
      rst_n = 1'b1;
      do_add("post_rst", 16'h0102, 16'h0304, 1'b0, 17'h00406, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
